// File: rtl/pipeline_hold_ctrl.sv
// Pipeline hold/flush controller for a multi-cycle mul/div unit with load-use stalls.
// Optional mul/div watchdog compiled in with `define MD_TIMEOUT_EN.
module pipeline_hold_ctrl #(
  parameter int MD_TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic ex_valid,
  input  logic ex_is_mul_div,
  input  logic md_done,
  input  logic load_use_hazard,
  input  logic branch_flush,
  input  logic trap_flush,
  output logic idex_hold,
  output logic idex_flush,
  output logic ifid_hold,
  output logic pc_hold,
  output logic md_start,
  output logic md_abort,
  output logic md_busy,
  output logic flush_pending,
  output logic md_timeout_err
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   flush_pending_q, flush_pending_d;
  logic   start_cond;
  logic   timeout_hit;
  logic   timeout_err_q;

  assign start_cond = ex_valid && ex_is_mul_div && !trap_flush;

`ifdef MD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MD_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_d;

  // md_done and trap_flush both end the wait first, so a timeout only fires when neither is present.
  assign timeout_hit = (state_q == MD_WAIT) && (cnt_q == CNT_MAX) &&
                       !md_done && !trap_flush && !reset;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_d == MD_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_err_d = timeout_err_q || timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (MD_TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err_q      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_cond) state_d = MD_WAIT;
      MD_WAIT: if (trap_flush || md_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idex_hold      = 1'b0;
    idex_flush     = 1'b0;
    ifid_hold      = 1'b0;
    pc_hold        = 1'b0;
    md_start       = 1'b0;
    md_abort       = 1'b0;
    md_busy        = 1'b0;
    flush_pending  = 1'b0;
    md_timeout_err = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (start_cond) begin
            idex_hold = 1'b1;
            md_start  = 1'b1;
          end
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          if (trap_flush || timeout_hit) begin
            md_abort = 1'b1;
          end else if (!md_done) begin
            idex_hold = 1'b1;
          end
        end
        default: ;
      endcase
      // A hold masks every flush source; a pending branch flush drains when the hold drops.
      idex_flush     = (!idex_hold && (trap_flush || branch_flush ||
                                       flush_pending_q || load_use_hazard)) || timeout_hit;
      ifid_hold      = idex_hold || (load_use_hazard && !idex_hold && !trap_flush &&
                                     !branch_flush && !flush_pending_q);
      pc_hold        = ifid_hold;
      flush_pending  = flush_pending_q;
      md_timeout_err = timeout_err_q;
    end
  end

  always_comb begin
    flush_pending_d = flush_pending_q;
    if (trap_flush) begin
      flush_pending_d = 1'b0;
    end else if (idex_hold) begin
      flush_pending_d = flush_pending_q || branch_flush;
    end else begin
      flush_pending_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Directed bench for pipeline_hold_ctrl; expected output vectors are queued at drive time and checked mid-cycle.
module tb_pipeline_hold_ctrl;

  logic clk = 1'b0;
  logic reset, ex_valid, ex_is_mul_div, md_done, load_use_hazard, branch_flush, trap_flush;
  logic idex_hold, idex_flush, ifid_hold, pc_hold, md_start, md_abort, md_busy;
  logic flush_pending, md_timeout_err;

  always #5 clk = ~clk;

  pipeline_hold_ctrl #(.MD_TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_mul_div(ex_is_mul_div),
    .md_done(md_done), .load_use_hazard(load_use_hazard), .branch_flush(branch_flush),
    .trap_flush(trap_flush), .idex_hold(idex_hold), .idex_flush(idex_flush),
    .ifid_hold(ifid_hold), .pc_hold(pc_hold), .md_start(md_start), .md_abort(md_abort),
    .md_busy(md_busy), .flush_pending(flush_pending), .md_timeout_err(md_timeout_err)
  );

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  wire [8:0] obs = {idex_hold, idex_flush, ifid_hold, pc_hold, md_start,
                    md_abort, md_busy, flush_pending, md_timeout_err};

  // inputs: reset, ex_valid, ex_is_mul_div, md_done, load_use_hazard, branch_flush, trap_flush
  function automatic logic [6:0] fi(input logic r, v, m, d, l, b, t);
    return {r, v, m, d, l, b, t};
  endfunction

  // outputs: idex_hold, idex_flush, ifid_hold/pc_hold, md_start, md_abort, md_busy, flush_pending, err
  function automatic logic [8:0] fo(input logic h, f, hz, s, a, b, fp, e);
    return {h, f, hz, hz, s, a, b, fp, e};
  endfunction

  task automatic check();
    sb_t e;
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] stim, input logic [8:0] exp);
    {reset, ex_valid, ex_is_mul_div, md_done, load_use_hazard, branch_flush, trap_flush} = stim;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] z, st, wt;
    logic [6:0] nop, mul, done;
    z    = fo(0, 0, 0, 0, 0, 0, 0, 0);
    st   = fo(1, 0, 1, 1, 0, 0, 0, 0);
    wt   = fo(1, 0, 1, 0, 0, 1, 0, 0);
    nop  = fi(0, 0, 0, 0, 0, 0, 0);
    mul  = fi(0, 1, 1, 0, 0, 0, 0);
    done = fi(0, 1, 1, 1, 0, 0, 0);

    step("rst0",          fi(1, 0, 0, 0, 0, 0, 0), z);
    step("rst_all_in",    fi(1, 1, 1, 1, 1, 1, 1), z);
    step("idle",          nop, z);

    // mul issued at c0, result at c5
    step("mul_c0", mul, st);
    for (int c = 1; c <= 4; c++) step($sformatf("mul_c%0d", c), mul, wt);
    step("mul_c5_done",   done, fo(0, 0, 0, 0, 0, 1, 0, 0));
    step("mul_c6_idle",   nop, z);

    // branch during hold is deferred until the hold releases
    step("brh_c0", mul, st);
    step("brh_c1", mul, wt);
    step("brh_c2_branch", fi(0, 1, 1, 0, 0, 1, 0), wt);
    step("brh_c3_pend",   mul, fo(1, 0, 1, 0, 0, 1, 1, 0));
    step("brh_c4_done",   done, fo(0, 1, 0, 0, 0, 1, 1, 0));
    step("brh_c5_clear",  nop, z);

    // trap beats a simultaneous md_done
    step("trp_c0", mul, st);
    step("trp_c1", mul, wt);
    step("trp_c2_trap_done", fi(0, 1, 1, 1, 0, 0, 1), fo(0, 1, 0, 0, 1, 1, 0, 0));
    step("trp_c3_idle",   nop, z);

    // trap clears a pending branch flush
    step("tfp_c0", mul, st);
    step("tfp_c1_branch", fi(0, 1, 1, 0, 0, 1, 0), wt);
    step("tfp_c2_trap",   fi(0, 1, 1, 0, 0, 0, 1), fo(0, 1, 0, 0, 1, 1, 1, 0));
    step("tfp_c3_idle",   nop, z);

    // load-use stalls
    step("lu_idle",       fi(0, 0, 0, 0, 1, 0, 0), fo(0, 1, 1, 0, 0, 0, 0, 0));
    step("lu_after",      nop, z);
    step("lu_branch",     fi(0, 0, 0, 0, 1, 1, 0), fo(0, 1, 0, 0, 0, 0, 0, 0));
    step("lu_hold_c0",    fi(0, 1, 1, 0, 1, 0, 0), st);
    step("lu_hold_c1",    fi(0, 1, 1, 0, 1, 0, 0), wt);
    step("lu_hold_done",  fi(0, 1, 1, 1, 1, 0, 0), fo(0, 1, 1, 0, 0, 1, 0, 0));
    step("lu_hold_idle",  nop, z);
    step("idle_trap_mul", fi(0, 1, 1, 0, 0, 0, 1), fo(0, 1, 0, 0, 0, 0, 0, 0));
    step("idle_branch",   fi(0, 0, 0, 0, 0, 1, 0), fo(0, 1, 0, 0, 0, 0, 0, 0));
    step("idle_after_br", nop, z);

    // reset in the middle of MD_WAIT, with a trap present, must not abort
    step("rmw_c0", mul, st);
    step("rmw_c1", mul, wt);
    step("rmw_c2", mul, wt);
    step("rmw_c3_reset",  fi(1, 1, 1, 0, 0, 0, 1), z);
    step("rmw_c4_restart", mul, st);
    step("rmw_c5_done",   done, fo(0, 0, 0, 0, 0, 1, 0, 0));
    step("rmw_c6_idle",   nop, z);

    // long wait with no md_done
    step("to_c0", mul, st);
    for (int c = 1; c <= 4; c++) step($sformatf("to_c%0d", c), mul, wt);
`ifdef MD_TIMEOUT_EN
    step("to_c5_abort",   mul, fo(0, 1, 0, 0, 1, 1, 0, 0));
    step("to_c6_err",     nop, fo(0, 0, 0, 0, 0, 0, 0, 1));
    step("to_c7_restart", mul, fo(1, 0, 1, 1, 0, 0, 0, 1));
    step("to_c8_done",    done, fo(0, 0, 0, 0, 0, 1, 0, 1));
    step("to_c9_sticky",  nop, fo(0, 0, 0, 0, 0, 0, 0, 1));
`else
    for (int c = 5; c <= 8; c++) step($sformatf("to_c%0d_noabort", c), mul, wt);
    step("to_c9_done",    done, fo(0, 0, 0, 0, 0, 1, 0, 0));
    step("to_c10_idle",   nop, z);
`endif
    step("to_reset",      fi(1, 0, 0, 0, 0, 0, 0), z);
    step("to_post_reset", nop, z);

    n_cmp++;
    assert (sb_q.size() === 0) else begin
      n_bad++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
